// File: rtl/ask_envelope_demod.sv
// ask_envelope_demod: single-clock non-coherent ASK demodulator with onset alignment, per-symbol integrate-and-dump and lock tracking
// Ports:
//   clk_fast  - sole clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   wav_in    - 8-bit offset-binary waveform sample, one per clk_fast
//   bit_out   - last decided bit, held between decisions
//   bit_valid - one-cycle pulse marking a new bit_out
//   locked    - high while tracking symbols
module ask_envelope_demod #(
  parameter int SPS       = 16,
  parameter int MID       = 128,
  parameter int SAMPLE_TH = 24,
  parameter int THRESH    = 512,
  parameter int LOSS_SYMS = 8
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic [7:0] wav_in,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       locked
);
  localparam int CW = $clog2(SPS);
  localparam int AW = 8 + CW;
  localparam logic [7:0] MID_V = 8'(MID);
  localparam logic [7:0] STH_V = 8'(SAMPLE_TH);
  localparam logic [7:0] ZR_LAST = 8'(LOSS_SYMS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
  typedef enum logic {SEARCH, TRACK} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] zrun_q, zrun_d, dev;
  logic bit_q, bit_d, valid_q, valid_d, onset, last, one, drop;
  assign dev = (wav_in >= MID_V) ? wav_in - MID_V : MID_V - wav_in;
  assign sum = acc_q + AW'(dev);
  assign onset = dev > STH_V;
  assign last = cnt_q == CNT_LAST;
  assign one = 32'(sum) >= unsigned'(THRESH);
  // final '0' of a run of LOSS_SYMS empty symbols drops lock on its own decision edge
  assign drop = last && !one && zrun_q == ZR_LAST;
  always_ff @(posedge clk_fast or posedge rst)
    if (rst) begin
      state_q <= SEARCH;
      acc_q   <= '0;
      cnt_q   <= '0;
      zrun_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      zrun_q  <= zrun_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
    end
  always_comb
    state_d = (state_q == SEARCH) ? (onset ? TRACK : SEARCH) : (drop ? SEARCH : TRACK);
  always_comb begin
    acc_d   = '0;
    cnt_d   = '0;
    zrun_d  = '0;
    bit_d   = bit_q;
    valid_d = 1'b0;
    if (state_q == SEARCH) begin
      acc_d = onset ? AW'(dev) : '0;
      cnt_d = onset ? CW'(1) : '0;
    end else begin
      acc_d   = last ? '0 : sum;
      // SPS is a power of two, so the counter wraps to 0 after the last sample
      cnt_d   = cnt_q + 1'b1;
      zrun_d  = !last ? zrun_q : (one || drop) ? '0 : zrun_q + 8'd1;
      bit_d   = last ? one : bit_q;
      valid_d = last;
    end
  end
  always_comb begin
    locked    = state_q == TRACK;
    bit_out   = bit_q;
    bit_valid = valid_q;
  end
endmodule

// File: tb/tb_ask_envelope_demod.sv
// tb_ask_envelope_demod: directed and randomized checks of ask_envelope_demod against a symbol-level reference model
module tb_ask_envelope_demod;
  localparam int SPS = 16, THRESH = 512, STH = 24, LOSS = 8;
  logic clk_fast = 1'b0, rst = 1'b1;
  logic [7:0] wav_in = 8'd128;
  logic bit_out, bit_valid, locked;
  int errs = 0, checks = 0;
  int hist[$];
  logic ov[$], ob[$], ol[$];
  logic ev[], eb[], el[];

  ask_envelope_demod dut (
    .clk_fast(clk_fast), .rst(rst), .wav_in(wav_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .locked(locked)
  );

  always #5 clk_fast = ~clk_fast;

  function automatic int dev(int s);
    return s >= 128 ? s - 128 : 128 - s;
  endfunction

  task automatic drive(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      wav_in = 8'(s);
      @(posedge clk_fast);
      #1;
      hist.push_back(s);
      ov.push_back(bit_valid);
      ob.push_back(bit_out);
      ol.push_back(locked);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_fast);
    rst = 1'b1;
    wav_in = 8'd128;
    @(negedge clk_fast);
    @(negedge clk_fast);
    rst = 1'b0;
    hist.delete(); ov.delete(); ob.delete(); ol.delete();
  endtask

  // Expected outputs after each edge since reset: find onset, sum whole symbols, decide, count empty symbols.
  function automatic void model();
    int n = hist.size();
    int i = 0;
    logic cur = 1'b0;
    ev = new[n]; eb = new[n]; el = new[n];
    while (i < n) begin
      if (dev(hist[i]) <= STH) begin
        ev[i] = 1'b0; eb[i] = cur; el[i] = 1'b0;
        i++;
      end else begin
        int zr = 0;
        bit run = 1'b1;
        while (run && i < n) begin
          int sum = 0;
          for (int k = 0; k < SPS && i + k < n; k++) begin
            sum += dev(hist[i+k]);
            ev[i+k] = 1'b0; eb[i+k] = cur; el[i+k] = 1'b1;
          end
          if (i + SPS > n) i = n;
          else begin
            cur = (sum >= THRESH);
            ev[i+SPS-1] = 1'b1;
            eb[i+SPS-1] = cur;
            zr = cur ? 0 : zr + 1;
            if (zr == LOSS) begin
              el[i+SPS-1] = 1'b0;
              run = 1'b0;
            end
            i += SPS;
          end
        end
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({bit_out, bit_valid, locked} !== 3'b000) begin
      errs++; $display("FAIL reset_outputs got %b exp 000", {bit_out, bit_valid, locked});
    end
    @(negedge clk_fast);
    @(negedge clk_fast);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int nv = 0, nl = 0;
    drive(128, 500);
    foreach (ov[k]) begin
      if (ov[k] !== 1'b0) nv++;
      if (ol[k] !== 1'b0) nl++;
    end
    checks++;
    if (nv != 0) begin errs++; $display("FAIL idle_valid got %0d pulses exp 0", nv); end
    checks++;
    if (nl != 0) begin errs++; $display("FAIL idle_locked got %0d locked cycles exp 0", nl); end
  endtask

  task automatic test_onset();
    int t = hist.size();
    for (int k = 0; k < 32; k++) drive((k % 2) ? 28 : 228, 1);
    checks++;
    if (ol[t-1] !== 1'b0) begin errs++; $display("FAIL onset_prelock got %b exp 0", ol[t-1]); end
    checks++;
    if (ol[t] !== 1'b1) begin errs++; $display("FAIL onset_lock got %b exp 1", ol[t]); end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (ov[t+k] !== (k == 15 || k == 31)) begin
        errs++; $display("FAIL onset_valid k=%0d got %b exp %b", k, ov[t+k], (k == 15 || k == 31));
      end
    end
    checks++;
    if (ob[t+15] !== 1'b1 || ob[t+31] !== 1'b1) begin
      errs++; $display("FAIL onset_bits got %b%b exp 11", ob[t+15], ob[t+31]);
    end
  endtask

  task automatic test_zero();
    int t = hist.size();
    drive(128, 16);
    checks++;
    if ({ov[t+14], ov[t+15], ob[t+15], ol[t+15]} !== 4'b0101) begin
      errs++; $display("FAIL zero_symbol got %b exp 0101", {ov[t+14], ov[t+15], ob[t+15], ol[t+15]});
    end
  endtask

  task automatic test_threshold();
    int t = hist.size();
    drive(160, 16);
    checks++;
    if ({ov[t+15], ob[t+15]} !== 2'b11) begin
      errs++; $display("FAIL thresh_512 got %b exp 11", {ov[t+15], ob[t+15]});
    end
    t = hist.size();
    drive(159, 16);
    checks++;
    if ({ov[t+15], ob[t+15], ol[t+15]} !== 3'b101) begin
      errs++; $display("FAIL thresh_496 got %b exp 101", {ov[t+15], ob[t+15], ol[t+15]});
    end
  endtask

  task automatic test_loss();
    int t, t2;
    for (int k = 0; k < 16; k++) drive((k % 2) ? 28 : 228, 1);
    t = hist.size();
    drive(128, 128);
    for (int s = 0; s < 8; s++) begin
      checks++;
      if ({ov[t+16*s+15], ob[t+16*s+15], ol[t+16*s+15]} !== {2'b10, s < 7}) begin
        errs++; $display("FAIL loss_sym%0d got %b exp %b", s, {ov[t+16*s+15], ob[t+16*s+15], ol[t+16*s+15]}, {2'b10, s < 7});
      end
    end
    checks++;
    if (ol[t+16*7+14] !== 1'b1) begin errs++; $display("FAIL loss_prefall got %b exp 1", ol[t+16*7+14]); end
    t2 = hist.size();
    drive(0, 16);
    checks++;
    if (ol[t2] !== 1'b1) begin errs++; $display("FAIL relock got %b exp 1", ol[t2]); end
    checks++;
    if ({ov[t2+15], ob[t2+15]} !== 2'b11) begin
      errs++; $display("FAIL relock_bit got %b exp 11", {ov[t2+15], ob[t2+15]});
    end
  endtask

  task automatic test_random();
    int a, len, lo, hi;
    do_reset();
    for (int g = 0; g < 80; g++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, STH);
        len = $urandom_range(1, 200);
      end else begin
        a = $urandom_range(0, 128);
        len = $urandom_range(1, 48);
      end
      lo = 128 - a;
      hi = (128 + a > 255) ? 255 : 128 + a;
      for (int k = 0; k < len; k++) drive($urandom_range(hi, lo), 1);
    end
    model();
    foreach (hist[k]) begin
      checks++;
      if ({ov[k], ob[k], ol[k]} !== {ev[k], eb[k], el[k]}) begin
        errs++; $display("FAIL random cyc=%0d valid/bit/locked got %b exp %b", k, {ov[k], ob[k], ol[k]}, {ev[k], eb[k], el[k]});
      end
    end
  endtask

  task automatic test_async_reset();
    int nv = 0, nl = 0;
    do_reset();
    drive(228, 16);
    drive(228, 7);
    checks++;
    if ({ob[$], ol[$]} !== 2'b11) begin errs++; $display("FAIL areset_pre got %b exp 11", {ob[$], ol[$]}); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bit_out, bit_valid, locked} !== 3'b000) begin
      errs++; $display("FAIL areset_immediate got %b exp 000", {bit_out, bit_valid, locked});
    end
    @(negedge clk_fast);
    @(negedge clk_fast);
    rst = 1'b0;
    hist.delete(); ov.delete(); ob.delete(); ol.delete();
    drive(128, 40);
    foreach (ov[k]) begin
      if (ov[k] !== 1'b0) nv++;
      if (ol[k] !== 1'b0) nl++;
    end
    checks++;
    if (nv != 0) begin errs++; $display("FAIL areset_valid got %0d pulses exp 0", nv); end
    checks++;
    if (nl != 0) begin errs++; $display("FAIL areset_locked got %0d locked cycles exp 0", nl); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_onset();
    test_zero();
    test_threshold();
    test_loss();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
